alu_seq_core: RTL and testbench

- Parametrised sequential ALU core. It is the next generation of the team's tiny processor datapath that sits behind the tt_um top-level pins.
- Replaces the fixed 4-bit combinational operand/result path with four additions: a WIDTH-generic operand path, a valid/ready handshake, iterative MUL/DIV, and status flags.
- The tt_um wrapper maps ui_in/uio_in onto a/b/op and maps result/flags onto uo_out/uio_out.

---
 rtl/alu_seq_pkg.sv | 18 +
 rtl/alu_seq_muldiv.sv | 60 ++++++
 rtl/alu_seq_core.sv | 127 ++++++++++++
 tb/tb_alu_seq_core.sv | 227 ++++++++++++++++++++++
 4 files changed

// File: rtl/alu_seq_pkg.sv
// alu_seq_pkg: opcodes, FSM states and flag bit positions shared by the sequential ALU.
package alu_seq_pkg;
  typedef enum logic [2:0] {OP_ADD, OP_SUB, OP_AND, OP_OR, OP_XOR, OP_SHL, OP_MUL, OP_DIV} op_e;
  typedef enum logic [1:0] {S_IDLE, S_EXEC, S_DONE} state_e;
  localparam int FLG_ZERO  = 0;
  localparam int FLG_CARRY = 1;
  localparam int FLG_OVF   = 2;
  localparam int FLG_DIVZ  = 3;
  function automatic logic [3:0] mk_flags(input logic divz, input logic ovf, input logic carry, input logic zero);
    logic [3:0] f;
    f = '0;
    f[FLG_DIVZ]  = divz;
    f[FLG_OVF]   = ovf;
    f[FLG_CARRY] = carry;
    f[FLG_ZERO]  = zero;
    return f;
  endfunction
endpackage

// File: rtl/alu_seq_muldiv.sv
// alu_seq_muldiv: iterative unsigned shift-add multiply / restoring divide, one bit per step.
module alu_seq_muldiv #(
  parameter int WIDTH = 4
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start,
  input  logic             op_is_div,
  input  logic             step,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  output logic             done,
  output logic [WIDTH-1:0] hi,
  output logic [WIDTH-1:0] lo
);
  localparam int CNTW = $clog2(WIDTH) + 1;
  logic [CNTW-1:0]  cnt_q, cnt_d;
  logic [WIDTH-1:0] hi_q, hi_d, lo_q, lo_d, mc_q, mc_d;
  logic             div_q, div_d;
  logic [WIDTH:0]   sum, rem_sh, rem_sub;
  always_comb begin
    sum     = {1'b0, hi_q} + (lo_q[0] ? {1'b0, mc_q} : '0);
    rem_sh  = {hi_q, lo_q[WIDTH-1]};
    rem_sub = rem_sh - {1'b0, mc_q};
    cnt_d   = cnt_q;
    hi_d    = hi_q;
    lo_d    = lo_q;
    mc_d    = mc_q;
    div_d   = div_q;
    if (start) begin
      cnt_d = CNTW'(WIDTH);
      hi_d  = '0;
      lo_d  = a;
      mc_d  = b;
      div_d = op_is_div;
    end else if (step && cnt_q != '0) begin
      cnt_d = cnt_q - CNTW'(1);
      hi_d  = div_q ? (rem_sub[WIDTH] ? rem_sh[WIDTH-1:0] : rem_sub[WIDTH-1:0]) : sum[WIDTH:1];
      lo_d  = div_q ? {lo_q[WIDTH-2:0], ~rem_sub[WIDTH]} : {sum[0], lo_q[WIDTH-1:1]};
    end
  end
  // Results are taken from the next-state values so the final step and DONE share an edge.
  assign done = step && cnt_q == CNTW'(1);
  assign hi   = hi_d;
  assign lo   = lo_d;
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) begin
      cnt_q <= '0;
      hi_q  <= '0;
      lo_q  <= '0;
      mc_q  <= '0;
      div_q <= 1'b0;
    end else begin
      cnt_q <= cnt_d;
      hi_q  <= hi_d;
      lo_q  <= lo_d;
      mc_q  <= mc_d;
      div_q <= div_d;
    end
endmodule

// File: rtl/alu_seq_core.sv
// alu_seq_core: valid/ready sequential ALU with single-cycle logic ops, iterative MUL/DIV and flags.
// Define ALU_SEQ_ACC_EN to add an accumulator selectable as operand A via acc_sel.
module alu_seq_core
  import alu_seq_pkg::*;
#(
  parameter int WIDTH = 4
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic               ena,
  input  logic               in_valid,
  output logic               in_ready,
  input  logic [2:0]         op,
  input  logic [WIDTH-1:0]   a,
  input  logic [WIDTH-1:0]   b,
  output logic               out_valid,
  input  logic               out_ready,
  output logic [2*WIDTH-1:0] result,
  output logic [3:0]         flags,
`ifdef ALU_SEQ_ACC_EN
  input  logic               acc_sel,
`endif
  output logic               busy
);
  localparam int CNTW = $clog2(WIDTH) + 1;
  state_e             state_q, state_d;
  logic [2*WIDTH-1:0] result_q, result_d, res_c;
  logic [3:0]         flags_q, flags_d;
  logic [WIDTH-1:0]   a_eff, mhi, mlo;
  logic [WIDTH:0]     sum_c, dif_c;
  logic               accept, long_op, md_done, carry_c, ovf_c, divz_c;
  op_e                op_c;
`ifdef ALU_SEQ_ACC_EN
  logic [WIDTH-1:0]   acc_q, acc_d;
  assign a_eff = acc_sel ? acc_q : a;
  assign acc_d = (ena && out_valid && out_ready) ? result_q[WIDTH-1:0] : acc_q;
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) acc_q <= '0;
    else acc_q <= acc_d;
`else
  assign a_eff = a;
`endif
  assign op_c      = op_e'(op);
  assign in_ready  = state_q == S_IDLE && ena;
  assign accept    = in_valid && in_ready;
  assign long_op   = op_c == OP_MUL || (op_c == OP_DIV && b != '0);
  assign out_valid = state_q == S_DONE;
  assign busy      = state_q == S_EXEC;
  assign result    = result_q;
  assign flags     = flags_q;
  alu_seq_muldiv #(.WIDTH(WIDTH)) u_muldiv (
    .clk      (clk),
    .rst_n    (rst_n),
    .start    (accept && long_op),
    .op_is_div(op_c == OP_DIV),
    .step     (ena && state_q == S_EXEC),
    .a        (a_eff),
    .b        (b),
    .done     (md_done),
    .hi       (mhi),
    .lo       (mlo)
  );
  always_comb begin
    sum_c   = {1'b0, a_eff} + {1'b0, b};
    dif_c   = {1'b0, a_eff} - {1'b0, b};
    res_c   = '0;
    carry_c = 1'b0;
    ovf_c   = 1'b0;
    divz_c  = 1'b0;
    case (op_c)
      OP_ADD: begin
        res_c   = (2*WIDTH)'(sum_c);
        carry_c = sum_c[WIDTH];
        ovf_c   = a_eff[WIDTH-1] == b[WIDTH-1] && sum_c[WIDTH-1] != a_eff[WIDTH-1];
      end
      OP_SUB: begin
        res_c   = (2*WIDTH)'(dif_c[WIDTH-1:0]);
        carry_c = dif_c[WIDTH];
        ovf_c   = a_eff[WIDTH-1] != b[WIDTH-1] && dif_c[WIDTH-1] != a_eff[WIDTH-1];
      end
      OP_AND:  res_c = (2*WIDTH)'(a_eff & b);
      OP_OR:   res_c = (2*WIDTH)'(a_eff | b);
      OP_XOR:  res_c = (2*WIDTH)'(a_eff ^ b);
      OP_SHL:  res_c = {{WIDTH{1'b0}}, a_eff} << b[CNTW-1:0];
      // Only reached single-cycle when b==0: quotient saturates, remainder is the dividend.
      OP_DIV: begin
        res_c  = {a_eff, {WIDTH{1'b1}}};
        divz_c = 1'b1;
      end
      default: res_c = '0;
    endcase
  end
  always_comb begin
    state_d  = state_q;
    result_d = result_q;
    flags_d  = flags_q;
    if (ena)
      case (state_q)
        S_IDLE:
          if (accept) begin
            state_d = long_op ? S_EXEC : S_DONE;
            if (!long_op) begin
              result_d = res_c;
              flags_d  = mk_flags(divz_c, ovf_c, carry_c, res_c == '0);
            end
          end
        S_EXEC:
          if (md_done) begin
            state_d  = S_DONE;
            result_d = {mhi, mlo};
            flags_d  = mk_flags(1'b0, 1'b0, 1'b0, {mhi, mlo} == '0);
          end
        S_DONE:  state_d = out_ready ? S_IDLE : S_DONE;
        default: state_d = S_IDLE;
      endcase
  end
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) begin
      state_q  <= S_IDLE;
      result_q <= '0;
      flags_q  <= '0;
    end else begin
      state_q  <= state_d;
      result_q <= result_d;
      flags_q  <= flags_d;
    end
endmodule

// File: tb/tb_alu_seq_core.sv
// tb_alu_seq_core: scoreboard bench for alu_seq_core at WIDTH=4 against an integer reference model.
module tb_alu_seq_core;
  localparam int W = 4;
  logic           clk = 1'b0, rst_n = 1'b0, ena = 1'b1, in_valid = 1'b0, out_ready = 1'b1;
  logic [2:0]     op = '0;
  logic [W-1:0]   a = '0, b = '0;
  logic           in_ready, out_valid, busy;
  logic [2*W-1:0] result;
  logic [3:0]     flags;
  typedef struct {logic [7:0] res; logic [3:0] fl; int lat;} exp_t;
  exp_t sb[$];
  int checks = 0, passed = 0;

  always #5 clk = ~clk;

  alu_seq_core #(.WIDTH(W)) dut (
    .clk(clk), .rst_n(rst_n), .ena(ena), .in_valid(in_valid), .in_ready(in_ready),
    .op(op), .a(a), .b(b), .out_valid(out_valid), .out_ready(out_ready),
    .result(result), .flags(flags), .busy(busy)
  );

  function automatic exp_t model(input logic [2:0] o, input logic [3:0] x, input logic [3:0] y);
    int xi, yi, sx, sy, r;
    bit c, v, dz;
    exp_t e;
    xi = int'(x); yi = int'(y); r = 0; c = 0; v = 0; dz = 0;
    sx = xi > 7 ? xi - 16 : xi;
    sy = yi > 7 ? yi - 16 : yi;
    case (o)
      3'd0: begin r = xi + yi; c = r > 15; v = (sx + sy > 7) || (sx + sy < -8); end
      3'd1: begin r = (xi - yi) & 15; c = xi < yi; v = (sx - sy > 7) || (sx - sy < -8); end
      3'd2: r = xi & yi;
      3'd3: r = xi | yi;
      3'd4: r = xi ^ yi;
      3'd5: r = (xi << (yi % 8)) & 255;
      3'd6: r = xi * yi;
      default: if (yi == 0) begin r = xi * 16 + 15; dz = 1; end else r = (xi % yi) * 16 + xi / yi;
    endcase
    e.res = 8'(r);
    e.fl  = {dz, v, c, r == 0};
    e.lat = (o == 3'd6 || (o == 3'd7 && yi != 0)) ? W + 1 : 1;
    return e;
  endfunction

  task automatic run_op(input logic [2:0] o, input logic [3:0] x, input logic [3:0] y,
                        output int lat, output int nbusy, output logic [7:0] res, output logic [3:0] fl);
    int n = 0;
    op = o; a = x; b = y; in_valid = 1'b1;
    while (!in_ready && n < 50) begin @(posedge clk); #1; n++; end
    @(posedge clk); #1;
    in_valid = 1'b0; lat = 1; nbusy = 0;
    while (!out_valid && lat < 50) begin nbusy += int'(busy); @(posedge clk); #1; lat++; end
    res = result; fl = flags;
    if (out_ready) begin @(posedge clk); #1; end
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    #12;
    checks++;
    if ({out_valid, busy, result, flags, in_ready} !== {1'b0, 1'b0, 8'h00, 4'h0, 1'b1})
      $display("FAIL reset: got ov=%b busy=%b res=%h fl=%b rdy=%b exp 0 0 00 0000 1", out_valid, busy, result, flags, in_ready);
    else passed++;
    rst_n = 1'b1;
    @(posedge clk); #1;
  endtask

  task automatic test_single_cycle();
    logic [10:0] t [9] = '{{3'd0,4'd9,4'd8}, {3'd0,4'd7,4'd1}, {3'd0,4'd0,4'd0}, {3'd1,4'd3,4'd5},
                           {3'd2,4'hA,4'h5}, {3'd3,4'hA,4'h5}, {3'd4,4'hF,4'hF}, {3'd1,4'h8,4'h1}, {3'd4,4'hC,4'h6}};
    exp_t e;
    int lat, nb;
    logic [7:0] r;
    logic [3:0] f;
    for (int i = 0; i < 9; i++) begin
      sb.push_back(model(t[i][10:8], t[i][7:4], t[i][3:0]));
      run_op(t[i][10:8], t[i][7:4], t[i][3:0], lat, nb, r, f);
      e = sb.pop_front();
      checks++;
      if (r !== e.res || f !== e.fl || lat != e.lat)
        $display("FAIL single op=%0d: got res=%h fl=%b lat=%0d exp res=%h fl=%b lat=%0d", t[i][10:8], r, f, lat, e.res, e.fl, e.lat);
      else passed++;
    end
  endtask

  task automatic test_shift();
    logic [10:0] t [4] = '{{3'd5,4'hF,4'd7}, {3'd5,4'd3,4'd4}, {3'd5,4'd9,4'd8}, {3'd5,4'd0,4'd3}};
    exp_t e;
    int lat, nb;
    logic [7:0] r;
    logic [3:0] f;
    for (int i = 0; i < 4; i++) begin
      sb.push_back(model(t[i][10:8], t[i][7:4], t[i][3:0]));
      run_op(t[i][10:8], t[i][7:4], t[i][3:0], lat, nb, r, f);
      e = sb.pop_front();
      checks++;
      if (r !== e.res || f !== e.fl || lat != e.lat)
        $display("FAIL shl a=%h b=%h: got res=%h fl=%b lat=%0d exp res=%h fl=%b lat=%0d", t[i][7:4], t[i][3:0], r, f, lat, e.res, e.fl, e.lat);
      else passed++;
    end
  endtask

  task automatic test_muldiv();
    logic [10:0] t [6] = '{{3'd6,4'd15,4'd15}, {3'd7,4'd13,4'd4}, {3'd7,4'd7,4'd0},
                           {3'd6,4'd0,4'd9}, {3'd7,4'd3,4'd9}, {3'd7,4'd15,4'd1}};
    exp_t e;
    int lat, nb;
    logic [7:0] r;
    logic [3:0] f;
    for (int i = 0; i < 6; i++) begin
      sb.push_back(model(t[i][10:8], t[i][7:4], t[i][3:0]));
      run_op(t[i][10:8], t[i][7:4], t[i][3:0], lat, nb, r, f);
      e = sb.pop_front();
      checks++;
      if (r !== e.res || f !== e.fl || lat != e.lat || nb != e.lat - 1)
        $display("FAIL muldiv op=%0d a=%0d b=%0d: got res=%h fl=%b lat=%0d busy=%0d exp res=%h fl=%b lat=%0d busy=%0d",
                 t[i][10:8], t[i][7:4], t[i][3:0], r, f, lat, nb, e.res, e.fl, e.lat, e.lat - 1);
      else passed++;
    end
  endtask

  task automatic test_backpressure();
    exp_t e;
    int lat, nb;
    logic [7:0] r;
    logic [3:0] f;
    out_ready = 1'b0;
    sb.push_back(model(3'd0, 4'd1, 4'd1));
    run_op(3'd0, 4'd1, 4'd1, lat, nb, r, f);
    e = sb.pop_front();
    for (int i = 0; i < 3; i++) begin
      checks++;
      if (out_valid !== 1'b1 || result !== e.res || flags !== e.fl || in_ready !== 1'b0)
        $display("FAIL backpressure cyc%0d: got ov=%b res=%h fl=%b rdy=%b exp ov=1 res=%h fl=%b rdy=0", i, out_valid, result, flags, in_ready, e.res, e.fl);
      else passed++;
      @(posedge clk); #1;
    end
    out_ready = 1'b1;
    @(posedge clk); #1;
    checks++;
    if (out_valid !== 1'b0 || in_ready !== 1'b1)
      $display("FAIL release: got ov=%b rdy=%b exp ov=0 rdy=1", out_valid, in_ready);
    else passed++;
  endtask

  task automatic test_ena_freeze();
    exp_t e;
    int lat;
    sb.push_back(model(3'd6, 4'd3, 4'd5));
    op = 3'd6; a = 4'd3; b = 4'd5; in_valid = 1'b1;
    @(posedge clk); #1;
    in_valid = 1'b0; ena = 1'b0; lat = 1;
    repeat (3) begin @(posedge clk); #1; lat++; end
    checks++;
    if (busy !== 1'b1 || in_ready !== 1'b0 || out_valid !== 1'b0)
      $display("FAIL ena_hold: got busy=%b rdy=%b ov=%b exp 1 0 0", busy, in_ready, out_valid);
    else passed++;
    ena = 1'b1;
    while (!out_valid && lat < 50) begin @(posedge clk); #1; lat++; end
    e = sb.pop_front();
    checks++;
    if (result !== e.res || flags !== e.fl || lat != e.lat + 3)
      $display("FAIL ena_mul: got res=%h fl=%b lat=%0d exp res=%h fl=%b lat=%0d", result, flags, lat, e.res, e.fl, e.lat + 3);
    else passed++;
    @(posedge clk); #1;
  endtask

  task automatic test_reset_mid_mul();
    exp_t e;
    int lat, nb;
    logic [7:0] r;
    logic [3:0] f;
    op = 3'd6; a = 4'd15; b = 4'd15; in_valid = 1'b1;
    @(posedge clk); #1;
    in_valid = 1'b0;
    @(posedge clk); #1;
    rst_n = 1'b0;
    #1;
    checks++;
    if (out_valid !== 1'b0 || result !== 8'h00 || busy !== 1'b0 || flags !== 4'h0)
      $display("FAIL mid_reset: got ov=%b res=%h busy=%b fl=%b exp 0 00 0 0000", out_valid, result, busy, flags);
    else passed++;
    #2 rst_n = 1'b1;
    @(posedge clk); #1;
    sb.push_back(model(3'd0, 4'd2, 4'd3));
    run_op(3'd0, 4'd2, 4'd3, lat, nb, r, f);
    e = sb.pop_front();
    checks++;
    if (r !== e.res || f !== e.fl || lat != e.lat)
      $display("FAIL after_reset add: got res=%h fl=%b lat=%0d exp res=%h fl=%b lat=%0d", r, f, lat, e.res, e.fl, e.lat);
    else passed++;
  endtask

  task automatic test_back_to_back();
    exp_t e;
    int lat, nb;
    logic [7:0] r;
    logic [3:0] f;
    logic [2:0] o;
    logic [3:0] x, y;
    for (int i = 0; i < 24; i++) begin
      o = 3'($urandom_range(0, 7));
      x = 4'($urandom_range(0, 15));
      y = 4'($urandom_range(0, 15));
      sb.push_back(model(o, x, y));
      run_op(o, x, y, lat, nb, r, f);
      e = sb.pop_front();
      checks++;
      if (r !== e.res || f !== e.fl || lat != e.lat)
        $display("FAIL random op=%0d a=%h b=%h: got res=%h fl=%b lat=%0d exp res=%h fl=%b lat=%0d", o, x, y, r, f, lat, e.res, e.fl, e.lat);
      else passed++;
    end
  endtask

  initial begin
    test_reset();
    test_single_cycle();
    test_shift();
    test_muldiv();
    test_backpressure();
    test_ena_freeze();
    test_reset_mid_mul();
    test_back_to_back();
    $display("%0d/%0d checks passed", passed, checks);
    $finish;
  end
endmodule
